// File: rtl/key_irq_ctrl_pkg.sv
// Shared definitions for the keyboard interrupt controller.
//   - default memory-mapped word addresses for KEY_DATA / KEY_STAT
//   - PS/2 break prefix code
//   - interrupt FSM state encoding
//   - status word packing helper
package key_irq_ctrl_pkg;

    localparam logic [11:0] KEY_DATA_ADDR_DEF = 12'hFF0;
    localparam logic [11:0] KEY_STAT_ADDR_DEF = 12'hFF1;
    localparam logic [7:0]  BREAK_CODE        = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } irq_state_e;

    // KEY_STAT layout: count in [14:8], sticky overflow in [0].
    function automatic logic [31:0] status_word(input logic [6:0] cnt, input logic ovf);
        return {16'b0, 1'b0, cnt, 7'b0, ovf};
    endfunction

endpackage

// File: rtl/key_fifo.sv
// DEPTH x 8 synchronous FIFO for buffered scan codes.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   push, din      write din at the tail (accepted when not full, or when a pop frees a slot)
//   pop            advance the head (ignored when empty)
//   dout           combinational head entry
//   full, empty    occupancy flags
//   count          entries held, 0..DEPTH
module key_fifo
    import key_irq_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A pop in the same cycle frees the slot a full FIFO needs for the push.
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/key_irq_ctrl.sv
// Keyboard interrupt controller: filters PS/2 break sequences, buffers make
// codes in a FIFO and raises key_interrupt to the processor, which drains the
// FIFO through the KEY_DATA (pop) and KEY_STAT (status / overflow clear) words.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   key_valid, key_code scan-code strobe from the PS/2 receiver
//   bus_addr, bus_rd    dmem word address and one-cycle read strobe
//   bus_wren, bus_wdata write strobe and data (bit0 clears overflow on KEY_STAT)
//   bus_rdata, bus_hit  registered read data / address-hit, valid the cycle after bus_rd
//   key_interrupt       registered level interrupt request
module key_irq_ctrl
    import key_irq_ctrl_pkg::*;
#(
    parameter int          DEPTH         = 8,
    parameter logic [11:0] KEY_DATA_ADDR = KEY_DATA_ADDR_DEF,
    parameter logic [11:0] KEY_STAT_ADDR = KEY_STAT_ADDR_DEF,
    parameter int          HOLDOFF       = 4,
    parameter bit          FILTER_BREAK  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic [11:0] bus_addr,
    input  logic        bus_rd,
    input  logic        bus_wren,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_hit,
    output logic        key_interrupt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    // HOLDOFF=0 still spends one cycle in HOLD, so the counter loads 0.
    localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : HW'(0);

    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          brk_q, brk_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          hit_q, hit_d;
    logic          irq_q, irq_d;
    logic [HW-1:0] hold_q, hold_d;
    irq_state_e    state_q, state_d;

    logic accept, data_sel, stat_sel, pop_ok, push_ok, ovf_set;
    logic unused_wdata;

    assign unused_wdata = ^bus_wdata[31:1];

    key_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (key_code),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Break filter, address decode, overflow and read-data path.
    always_comb begin
        brk_d  = brk_q;
        accept = 1'b0;
        if (key_valid) begin
            if (!FILTER_BREAK) begin
                accept = 1'b1;
            end else if (brk_q) begin
                // The code after F0 names the released key; swallow it.
                brk_d = 1'b0;
            end else if (key_code == BREAK_CODE) begin
                brk_d = 1'b1;
            end else begin
                accept = 1'b1;
            end
        end

        data_sel = (bus_addr == KEY_DATA_ADDR);
        stat_sel = (bus_addr == KEY_STAT_ADDR);
        pop_ok   = bus_rd && data_sel && !fifo_empty;
        push_ok  = accept && (!fifo_full || pop_ok);
        ovf_set  = accept && fifo_full && !pop_ok;

        ovf_d = ovf_q;
        if (bus_wren && stat_sel && bus_wdata[0]) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;

        rdata_d = '0;
        hit_d   = 1'b0;
        if (bus_rd) begin
            if (data_sel) begin
                hit_d = 1'b1;
                if (pop_ok) rdata_d = {24'b0, fifo_dout};
            end else if (stat_sel) begin
                hit_d   = 1'b1;
                rdata_d = status_word(7'(fifo_count), ovf_q);
            end
        end
    end

    // Interrupt FSM next-state.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (pop_ok) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    state_d = fifo_empty ? ST_IDLE : ST_ASSERT;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        irq_d = (state_d == ST_ASSERT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            irq_q   <= irq_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            brk_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            brk_q   <= brk_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
        end
    end

    assign bus_rdata     = rdata_q;
    assign bus_hit       = hit_q;
    assign key_interrupt = irq_q;

endmodule
